// File: rtl/fft_twiddle_pkg.sv
// Shared types and elaboration-time helpers for the FFT twiddle generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_twiddle_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} tw_state_e;

  localparam real TWO_PI = 6.283185307179586;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Rounded quarter-wave cosine sample m of an n-point circle, scaled so
  // 1.0 maps to 2^(w-1)-1. Evaluated only at elaboration to fill the ROM.
  function automatic int cos_q(input int m, input int n, input int w);
    real amp;
    real x;
    amp = $itor((1 << (w - 1)) - 1);
    x   = $cos(TWO_PI * $itor(m) / $itor(n)) * amp;
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/fft_twiddle_gen_if.sv
// Twiddle stream bundle: complex factor plus stage/last markers, valid/ready.
// Latency: n/a (wires only).
// Backpressure: transfer when tw_valid && tw_ready; master holds while stalled.
// master: drives tw_r, tw_i, tw_valid, tw_stage, tw_last_stage, tw_last.
// slave : drives tw_ready.
interface fft_twiddle_gen_if
  import fft_twiddle_pkg::*;
#(
  parameter int FFT_LEN    = 64,
  parameter int TWID_WIDTH = 16
);
  localparam int LOG2_LEN = log2_ceil(FFT_LEN);

  logic signed [TWID_WIDTH-1:0] tw_r;
  logic signed [TWID_WIDTH-1:0] tw_i;
  logic                         tw_valid;
  logic                         tw_ready;
  logic [LOG2_LEN-1:0]          tw_stage;
  logic                         tw_last_stage;
  logic                         tw_last;

  modport master (
    output tw_r, tw_i, tw_valid, tw_stage, tw_last_stage, tw_last,
    input  tw_ready
  );

  modport slave (
    input  tw_r, tw_i, tw_valid, tw_stage, tw_last_stage, tw_last,
    output tw_ready
  );
endinterface

// File: rtl/fft_twiddle_rom.sv
// Quarter-wave cosine ROM (N/4+1 entries), two independent read ports.
// Latency: 1 cycle from address to data.
// Backpressure: en low freezes both output registers.
// Ports: clk, rst_n, en, addr_a/addr_b (read addresses), dat_a/dat_b (data).
module fft_twiddle_rom
  import fft_twiddle_pkg::*;
#(
  parameter int FFT_LEN    = 64,
  parameter int TWID_WIDTH = 16,
  parameter int AW         = $clog2(FFT_LEN) - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [AW-1:0]                addr_a,
  input  logic [AW-1:0]                addr_b,
  output logic signed [TWID_WIDTH-1:0] dat_a,
  output logic signed [TWID_WIDTH-1:0] dat_b
);
  localparam int DEPTH = FFT_LEN / 4 + 1;

  logic signed [TWID_WIDTH-1:0] tab [DEPTH];

  for (genvar m = 0; m < DEPTH; m++) begin : g_tab
    localparam logic signed [TWID_WIDTH-1:0] VAL = TWID_WIDTH'(cos_q(m, FFT_LEN, TWID_WIDTH));
    assign tab[m] = VAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_a <= '0;
      dat_b <= '0;
    end else if (en) begin
      dat_a <= tab[addr_a];
      dat_b <= tab[addr_b];
    end
  end
endmodule

// File: rtl/fft_twiddle_gen.sv
// Radix-2 DIT twiddle stream for one full frame, folded from a quarter-wave ROM.
// Latency: first tw_valid 3 edges after the edge that samples start; 1/cycle after.
// Backpressure: global stall, counter and all 3 stages advance on !tw_valid || tw_ready.
// Ports: clk, rst_n, start (frame request), busy (frame in flight), tw (stream master).
module fft_twiddle_gen
  import fft_twiddle_pkg::*;
#(
  parameter int FFT_LEN    = 64,
  parameter int TWID_WIDTH = 16,
  parameter int LOG2_LEN   = $clog2(FFT_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  fft_twiddle_gen_if.master tw
);
  localparam int                  AW         = LOG2_LEN - 1;
  localparam logic [AW-1:0]       QTR        = AW'(FFT_LEN / 4);
  localparam logic [LOG2_LEN-1:0] LAST_STAGE = LOG2_LEN'(LOG2_LEN - 1);
  localparam logic [LOG2_LEN-1:0] SHIFT_BASE = LOG2_LEN'(AW);

  tw_state_e           state, state_nxt;
  logic                adv, issue, start_acc;
  logic [LOG2_LEN-1:0] stage;
  logic [AW-1:0]       k, k_mask, e_nxt;
  logic                k_end, frame_end;

  assign adv       = !tw.tw_valid || tw.tw_ready;
  assign k_end     = (k == '1);
  assign frame_end = k_end && (stage == LAST_STAGE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_acc = 1'b0;
    case (state)
      IDLE: if (start) begin
        start_acc = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (adv) begin
        issue = 1'b1;
        if (frame_end) state_nxt = DRAIN;
      end
      DRAIN: if (tw.tw_valid && tw.tw_ready && tw.tw_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // k walks the N/2 butterflies of a stage; its width makes it wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
      k     <= '0;
    end else if (start_acc) begin
      stage <= '0;
      k     <= '0;
    end else if (issue) begin
      k <= k + 1'b1;
      if (k_end) stage <= stage + 1'b1;
    end
  end

  // e = (k mod 2^stage) << (LOG2_LEN-1-stage)
  always_comb begin
    k_mask = '0;
    for (int b = 0; b < AW; b++) k_mask[b] = (b < int'(stage));
    e_nxt = (k & k_mask) << (SHIFT_BASE - stage);
  end

  // P1: exponent and markers
  logic                p1_vld, p1_ls, p1_last;
  logic [AW-1:0]       p1_e;
  logic [LOG2_LEN-1:0] p1_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld   <= 1'b0;
      p1_e     <= '0;
      p1_stage <= '0;
      p1_ls    <= 1'b0;
      p1_last  <= 1'b0;
    end else if (adv) begin
      p1_vld   <= issue;
      p1_e     <= e_nxt;
      p1_stage <= stage;
      p1_ls    <= k_end;
      p1_last  <= frame_end;
    end
  end

  // The MSB of e is the fold selector (e >= N/4); e_lo is e' = e - N/4.
  logic          p1_hi;
  logic [AW-1:0] e_lo, addr_a, addr_b;

  assign p1_hi  = p1_e[AW-1];
  assign e_lo   = {1'b0, p1_e[AW-2:0]};
  assign addr_a = p1_hi ? QTR - e_lo : p1_e;
  assign addr_b = p1_hi ? e_lo : QTR - p1_e;

  // P2: ROM read plus aligned markers
  logic signed [TWID_WIDTH-1:0] rom_a, rom_b;
  logic                         p2_vld, p2_hi, p2_ls, p2_last;
  logic [LOG2_LEN-1:0]          p2_stage;

  fft_twiddle_rom #(
    .FFT_LEN   (FFT_LEN),
    .TWID_WIDTH(TWID_WIDTH),
    .AW        (AW)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .dat_a (rom_a),
    .dat_b (rom_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_vld   <= 1'b0;
      p2_hi    <= 1'b0;
      p2_stage <= '0;
      p2_ls    <= 1'b0;
      p2_last  <= 1'b0;
    end else if (adv) begin
      p2_vld   <= p1_vld;
      p2_hi    <= p1_hi;
      p2_stage <= p1_stage;
      p2_ls    <= p1_ls;
      p2_last  <= p1_last;
    end
  end

  // P3: sign fold into the output register; the imaginary part is always -table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw.tw_valid      <= 1'b0;
      tw.tw_r          <= '0;
      tw.tw_i          <= '0;
      tw.tw_stage      <= '0;
      tw.tw_last_stage <= 1'b0;
      tw.tw_last       <= 1'b0;
    end else if (adv) begin
      tw.tw_valid      <= p2_vld;
      tw.tw_r          <= p2_hi ? -rom_a : rom_a;
      tw.tw_i          <= -rom_b;
      tw.tw_stage      <= p2_vld ? p2_stage : '0;
      tw.tw_last_stage <= p2_vld && p2_ls;
      tw.tw_last       <= p2_vld && p2_last;
    end
  end
endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Bench for fft_twiddle_gen: N=8 exact-value scenarios and an N=64 tolerance frame.
// Scoreboard queues filled on accepted start; monitors pop on every transfer.
// Random tw_ready backpressure with hold-stability checks while stalled.
module tb_fft_twiddle_gen;
  localparam int W   = 16;
  localparam int AMP = (1 << (W - 1)) - 1;

  typedef struct packed {
    int r;
    int i;
    int stage;
    bit ls;
    bit last;
  } tw_exp_t;

  logic clk = 1'b0;
  logic rst_n, start8, start64, busy8, busy64;
  int   n_chk = 0, n_pass = 0, n_xfer8 = 0, n_xfer64 = 0;
  bit   frame_open8 = 0, frame_open64 = 0, bp8 = 0, bp64 = 0;
  tw_exp_t q8[$];
  tw_exp_t q64[$];

  fft_twiddle_gen_if #(.FFT_LEN(8),  .TWID_WIDTH(W)) tw8();
  fft_twiddle_gen_if #(.FFT_LEN(64), .TWID_WIDTH(W)) tw64();

  fft_twiddle_gen #(.FFT_LEN(8), .TWID_WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .tw(tw8)
  );
  fft_twiddle_gen #(.FFT_LEN(64), .TWID_WIDTH(W)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .busy(busy64), .tw(tw64)
  );

  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Stage-s butterflies span 2^(s+1) points, so butterfly k uses
  // W_{2^(s+1)}^(k mod 2^s) = W_N^((k mod 2^s) * N / 2^(s+1)).
  function automatic tw_exp_t model(input int n, input int s, input int k);
    tw_exp_t t;
    int      e;
    real     ang;
    e       = (k % (1 << s)) * (n >> (s + 1));
    ang     = 2.0 * 3.141592653589793 * $itor(e) / $itor(n);
    t.r     = rnd($cos(ang) * $itor(AMP));
    t.i     = -rnd($sin(ang) * $itor(AMP));
    t.stage = s;
    t.ls    = (k == n / 2 - 1);
    t.last  = t.ls && (s == $clog2(n) - 1);
    return t;
  endfunction

  task automatic push8();
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 4; k++) q8.push_back(model(8, s, k));
  endtask

  task automatic push64();
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < 32; k++) q64.push_back(model(64, s, k));
  endtask

  // One-cycle start pulse; the model accepts it only when no frame is open.
  task automatic pulse_start8();
    @(posedge clk); #1;
    start8 = 1'b1;
    if (!frame_open8) begin
      push8();
      frame_open8 = 1;
    end
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_idle8(input int budget);
    int c;
    c = 0;
    while (frame_open8 && c < budget) begin
      @(negedge clk); #2;
      c++;
    end
    chk(!frame_open8, $sformatf("timeout8 frame still open after %0d cycles, need closed", c));
  endtask

  // Ready driver: always-ready unless backpressure is enabled for that stream.
  initial begin
    tw8.tw_ready  = 1'b1;
    tw64.tw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tw8.tw_ready  = bp8  ? 1'($urandom_range(0, 1)) : 1'b1;
      tw64.tw_ready = bp64 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : mon8
    tw_exp_t got, held, e;
    bit      holding;
    holding = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) holding = 0;
      else begin
        got = '{int'(tw8.tw_r), int'(tw8.tw_i), int'(tw8.tw_stage), tw8.tw_last_stage, tw8.tw_last};
        if (holding)
          chk(tw8.tw_valid && got == held,
              $sformatf("hold8 got v=%0b r=%0d i=%0d st=%0d, need v=1 r=%0d i=%0d st=%0d",
                        tw8.tw_valid, got.r, got.i, got.stage, held.r, held.i, held.stage));
        holding = 0;
        if (tw8.tw_valid && tw8.tw_ready) begin
          n_xfer8++;
          chk(q8.size() != 0, $sformatf("xfer8 unexpected transfer r=%0d i=%0d, need none", got.r, got.i));
          if (q8.size() != 0) begin
            e = q8.pop_front();
            chk(got == e, $sformatf("xfer8 #%0d got r=%0d i=%0d st=%0d ls=%0b last=%0b, need r=%0d i=%0d st=%0d ls=%0b last=%0b",
                                    n_xfer8, got.r, got.i, got.stage, got.ls, got.last,
                                    e.r, e.i, e.stage, e.ls, e.last));
            if (e.last) frame_open8 = 0;
          end
        end else if (tw8.tw_valid) begin
          holding = 1;
          held    = got;
        end
      end
    end
  end

  initial begin : mon64
    tw_exp_t got, held, e;
    bit      holding;
    holding = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) holding = 0;
      else begin
        got = '{int'(tw64.tw_r), int'(tw64.tw_i), int'(tw64.tw_stage), tw64.tw_last_stage, tw64.tw_last};
        if (holding)
          chk(tw64.tw_valid && got == held,
              $sformatf("hold64 got v=%0b r=%0d i=%0d, need v=1 r=%0d i=%0d",
                        tw64.tw_valid, got.r, got.i, held.r, held.i));
        holding = 0;
        if (tw64.tw_valid && tw64.tw_ready) begin
          n_xfer64++;
          chk(q64.size() != 0, $sformatf("xfer64 unexpected transfer r=%0d i=%0d, need none", got.r, got.i));
          if (q64.size() != 0) begin
            e = q64.pop_front();
            chk(iabs(got.r - e.r) <= 1 && iabs(got.i - e.i) <= 1 &&
                iabs(got.r) <= AMP && iabs(got.i) <= AMP &&
                got.stage == e.stage && got.ls == e.ls && got.last == e.last,
                $sformatf("xfer64 #%0d got r=%0d i=%0d st=%0d ls=%0b last=%0b, need r=%0d+-1 i=%0d+-1 st=%0d ls=%0b last=%0b",
                          n_xfer64, got.r, got.i, got.stage, got.ls, got.last,
                          e.r, e.i, e.stage, e.ls, e.last));
            if (e.last) frame_open64 = 0;
          end
        end else if (tw64.tw_valid) begin
          holding = 1;
          held    = got;
        end
      end
    end
  end

  initial begin : stim
    int base, c;
    rst_n   = 1'b1;
    start8  = 1'b0;
    start64 = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk(tw8.tw_valid == 0 && tw8.tw_r == 0 && tw8.tw_i == 0 && busy8 == 0,
        $sformatf("reset8 got v=%0b r=%0d i=%0d busy=%0b, need all 0", tw8.tw_valid, tw8.tw_r, tw8.tw_i, busy8));
    chk(tw8.tw_stage == 0 && tw8.tw_last_stage == 0 && tw8.tw_last == 0,
        $sformatf("reset8 markers got st=%0d ls=%0b last=%0b, need 0", tw8.tw_stage, tw8.tw_last_stage, tw8.tw_last));
    chk(tw64.tw_valid == 0 && busy64 == 0,
        $sformatf("reset64 got v=%0b busy=%0b, need 0", tw64.tw_valid, busy64));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency and a full-rate frame.
    base = n_xfer8;
    pulse_start8();
    @(posedge clk); #1;
    chk(busy8 == 1 && tw8.tw_valid == 0, $sformatf("lat T1 got busy=%0b v=%0b, need busy=1 v=0", busy8, tw8.tw_valid));
    @(posedge clk); #1;
    chk(tw8.tw_valid == 0, $sformatf("lat T2 got v=%0b, need 0", tw8.tw_valid));
    @(posedge clk); #1;
    chk(tw8.tw_valid == 1, $sformatf("lat T3 got v=%0b, need 1", tw8.tw_valid));
    wait_idle8(100);
    @(posedge clk); #1;
    chk(busy8 == 0, $sformatf("busy after last got %0b, need 0", busy8));
    chk(n_xfer8 - base == 12, $sformatf("count frameA got %0d, need 12", n_xfer8 - base));

    // Mid-frame starts are ignored; a start right after busy falls is taken.
    base = n_xfer8;
    pulse_start8();
    repeat (2) @(posedge clk);
    pulse_start8();
    pulse_start8();
    wait_idle8(100);
    chk(n_xfer8 - base == 12, $sformatf("count ignore got %0d, need 12", n_xfer8 - base));
    bp8 = 1;
    pulse_start8();
    chk(busy8 == 1, $sformatf("back-to-back start got busy=%0b, need 1", busy8));
    wait_idle8(300);
    chk(n_xfer8 - base == 24, $sformatf("count two frames got %0d, need 24", n_xfer8 - base));

    // Asynchronous reset while transfer 6 is on the bus.
    bp8 = 0;
    repeat (2) @(posedge clk);
    base = n_xfer8;
    pulse_start8();
    c = 0;
    while (n_xfer8 < base + 5 && c < 100) begin
      @(negedge clk); #2;
      c++;
    end
    chk(c < 100, $sformatf("timeout waiting for transfer 5 got %0d xfers", n_xfer8 - base));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk(tw8.tw_valid == 0 && tw8.tw_r == 0 && tw8.tw_i == 0,
        $sformatf("async rst got v=%0b r=%0d i=%0d, need 0", tw8.tw_valid, tw8.tw_r, tw8.tw_i));
    chk(tw8.tw_stage == 0 && tw8.tw_last_stage == 0 && tw8.tw_last == 0 && busy8 == 0,
        $sformatf("async rst markers got st=%0d ls=%0b last=%0b busy=%0b, need 0",
                  tw8.tw_stage, tw8.tw_last_stage, tw8.tw_last, busy8));
    q8.delete();
    frame_open8 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(busy8 == 0 && tw8.tw_valid == 0, $sformatf("post rst got busy=%0b v=%0b, need 0", busy8, tw8.tw_valid));

    // Fresh frame after reset, under backpressure.
    bp8 = 1;
    base = n_xfer8;
    pulse_start8();
    wait_idle8(300);
    chk(n_xfer8 - base == 12, $sformatf("count after rst got %0d, need 12", n_xfer8 - base));
    bp8 = 0;

    // N=64 frame under backpressure against the float reference.
    bp64 = 1;
    @(posedge clk); #1;
    start64 = 1'b1;
    push64();
    frame_open64 = 1;
    @(posedge clk); #1;
    start64 = 1'b0;
    c = 0;
    while (frame_open64 && c < 3000) begin
      @(negedge clk); #2;
      c++;
    end
    chk(!frame_open64, $sformatf("timeout64 frame still open after %0d cycles, need closed", c));
    chk(n_xfer64 == 192, $sformatf("count64 got %0d, need 192", n_xfer64));
    bp64 = 0;

    repeat (5) @(posedge clk);
    #1;
    chk(q8.size() == 0 && q64.size() == 0,
        $sformatf("leftover expected got q8=%0d q64=%0d, need 0", q8.size(), q64.size()));
    chk(busy8 == 0 && busy64 == 0, $sformatf("final busy got %0b/%0b, need 0", busy8, busy64));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fft_twiddle_gen.md
Name: fft_twiddle_gen

Overview:
- Produces the twiddle-factor stream (W_N^e = cos(2πe/N) − j·sin(2πe/N)) that drives the b_r/b_i operands of the FFT complex multiplier.
- Covers one radix-2 DIT frame: all log2(N) stages, N/2 twiddles per stage, in butterfly order.
- Stores only a quarter-wave cosine table and reconstructs the other values by symmetry folding.
- Output is a valid/ready stream with stage and last markers, so the datapath can stall it.

Parameters:
- FFT_LEN, 64, transform length N; power of two, ≥ 8.
- TWID_WIDTH, 16, twiddle width; signed Q1.(TWID_WIDTH−1).
- LOG2_LEN, $clog2(FFT_LEN), derived; must not be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle frame request; ignored while busy=1
- busy  out  1  high from the start acceptance until the tw_last transfer completes
- tw_r  out  TWID_WIDTH  twiddle real part, signed
- tw_i  out  TWID_WIDTH  twiddle imaginary part, signed
- tw_valid  out  1  tw_* and the marker outputs are valid
- tw_ready  in  1  downstream accepts; a transfer occurs when tw_valid && tw_ready
- tw_stage  out  LOG2_LEN  stage index of the current twiddle, 0..LOG2_LEN−1
- tw_last_stage  out  1  last twiddle of the current stage
- tw_last  out  1  last twiddle of the frame

Behaviour:
- Reset: all outputs 0. The state machine goes to IDLE and pipeline valids clear. Reset asserted mid-frame aborts immediately; no partial-frame resume.
- State machine:
  - IDLE → RUN on start. Counters stage=0 and k=0; busy=1 from the next edge.
  - RUN → DRAIN when the counter issues (stage=LOG2_LEN−1, k=N/2−1).
  - DRAIN → IDLE when the tw_last transfer completes.
- Counter k runs 0..N/2−1 and wraps to 0 with stage+1.
- Exponent: j = k mod 2^stage; e = j << (LOG2_LEN−1−stage); e ranges 0..N/2−1.
  - Stage 0 therefore gives e=0 throughout.
  - The last stage gives e=k.
- Table: cos_tab[m] = round(cos(2πm/N)·(2^(TWID_WIDTH−1)−1)) for m=0..N/4, so 1.0 → +32767 at 16 bits.
- Folding:
  - If e < N/4: tw_r = cos_tab[e], tw_i = −cos_tab[N/4−e].
  - Else, with e' = e−N/4: tw_r = −cos_tab[N/4−e'], tw_i = −cos_tab[e'].
  - Negation is exact; table magnitudes never exceed 2^(TWID_WIDTH−1)−1, so no overflow.
- Pipeline: 3 registered stages.
  - P1: e, fold selector, markers.
  - P2: synchronous table read, two ports.
  - P3: negate/select into the output register.
- Latency: first tw_valid is asserted on the 3rd rising edge after the edge that samples start. With tw_ready held high, there is one twiddle per cycle and N/2·LOG2_LEN consecutive transfers.
- Backpressure: pipeline advance enable = !tw_valid || tw_ready, applied to the counter and all stages (global stall).
  - While tw_valid && !tw_ready, all tw_* outputs and markers hold stable.
- tw_stage, tw_last_stage and tw_last travel in the pipeline aligned to their twiddle.
- busy falls on the edge completing the tw_last transfer.
  - start sampled in that same cycle is ignored.
  - start in the following cycle starts a new frame.
- start while busy=1: no effect.

Decomposition:
- Package fft_twiddle_pkg holds:
  - function cos_q(m, N, W), returning a rounded signed constant, used at elaboration;
  - the state enum {IDLE, RUN, DRAIN};
  - function log2 helpers.
- Sub-module fft_twiddle_rom: dual-read-port synchronous ROM of N/4+1 entries, contents from cos_q; 1-cycle read latency. The top level holds the counters, FSM, folding and handshake.

Test Plan:
- N=8, W=16, tw_ready=1, single start pulse → exactly 12 transfers:
  - stage0: 4× (32767, 0);
  - stage1: (32767,0), (0,−32767), (32767,0), (0,−32767);
  - stage2: (32767,0), (23170,−23170), (0,−32767), (−23170,−23170).
  - tw_last_stage high on transfers 4, 8 and 12; tw_last only on 12.
- Latency: start sampled at edge T0 → tw_valid=1 after edge T3, busy=1 after T1, busy=0 after the edge completing transfer 12.
- Backpressure: N=8, tw_ready toggled in a pseudo-random pattern (~50% duty) → same 12-value sequence. Outputs are stable whenever tw_valid && !tw_ready, with no drops or duplicates.
- start pulses at cycles 5 and 7 of an active frame → ignored, still exactly 12 transfers. start the cycle after busy falls → a second identical frame.
- Reset mid-frame: rst_n low at transfer 6 → all outputs 0 asynchronously; after release, busy=0. A new start gives a full frame from stage0.
- N=64 frame → all 192 outputs match a float reference within ±1 LSB, and |tw_r|,|tw_i| ≤ 32767.
